redirect_ctrl: RTL and testbench

- Sequences front-end recovery after an ID-stage misprediction: consumes the 3-bit flush code from the misprediction detector, selects the correct redirect PC, and drives the PC-redirect and IF/ID-flush strobes.
- Defers recovery while the hazard unit stalls, and masks the detector during the squashed shadow.
- Keeps saturating misprediction statistics.
- Sits between the ID-stage misprediction detector, the hazard unit and the PC/IF-ID pipeline registers.

---
 rtl/redirect_ctrl.sv | 177 +++++++++++++++++
 tb/tb_redirect_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/redirect_ctrl.sv
// Front-end recovery sequencer: turns an ID-stage flush code into a PC
// redirect plus IF/ID flush, defers it across hazard stalls, masks the
// detector for a short shadow afterwards and keeps misprediction statistics.
module redirect_ctrl #(
  parameter int WORD_SIZE     = 16,
  parameter int CNT_WIDTH     = 16,
  parameter int SHADOW_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 id_valid,
  input  logic [2:0]           flush_code,
  input  logic                 stall,
  input  logic [WORD_SIZE-1:0] jmp_target,
  input  logic [WORD_SIZE-1:0] br_target,
  input  logic [WORD_SIZE-1:0] pc_1_ID,
  input  logic [WORD_SIZE-1:0] jr_target,
  input  logic                 cnt_clear,
  output logic                 redirect_valid,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 flush_if_id,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] mispred_cnt,
  output logic [CNT_WIDTH-1:0] br_mispred_cnt,
  output logic                 bad_code
);

  localparam logic [2:0] JMP_FLUSH = 3'd1;
  localparam logic [2:0] BR_FLUSH  = 3'd2;
  localparam logic [2:0] NBR_FLUSH = 3'd3;
  localparam logic [2:0] JR_FLUSH  = 3'd4;

  localparam int SW = $clog2(SHADOW_CYCLES + 1);
  localparam logic [SW-1:0] SHADOW_LOAD = SW'(SHADOW_CYCLES);
  localparam logic [SW-1:0] SHADOW_LAST = SW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SHADOW  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_SIZE-1:0]   tgt_q, tgt_d;
  logic [2:0]             code_q, code_d;
  logic [SW-1:0]          shad_q, shad_d;
  logic [CNT_WIDTH-1:0]   mis_q, mis_d;
  logic [CNT_WIDTH-1:0]   br_q, br_d;
  logic                   bad_q, bad_d;

  logic [WORD_SIZE-1:0]   sel_tgt;
  logic                   code_legal;
  logic                   code_illegal;
  logic                   detect;
  logic                   fire;
  logic                   fire_br;
  logic                   set_bad;

  // Live target mux and code classification.
  always_comb begin
    sel_tgt      = '0;
    code_legal   = 1'b0;
    code_illegal = (flush_code > JR_FLUSH);
    case (flush_code)
      JMP_FLUSH: begin sel_tgt = jmp_target; code_legal = 1'b1; end
      BR_FLUSH:  begin sel_tgt = br_target;  code_legal = 1'b1; end
      NBR_FLUSH: begin sel_tgt = pc_1_ID;    code_legal = 1'b1; end
      JR_FLUSH:  begin sel_tgt = jr_target;  code_legal = 1'b1; end
      default:   begin sel_tgt = '0;         code_legal = 1'b0; end
    endcase
  end

  // reset_n gates detection so no strobe can leak out while reset is held.
  assign detect = reset_n && id_valid && code_legal && (state_q == IDLE);

  // Next-state and Mealy strobe logic.
  always_comb begin
    state_d        = state_q;
    tgt_d          = tgt_q;
    code_d         = code_q;
    shad_d         = shad_q;
    fire           = 1'b0;
    fire_br        = 1'b0;
    set_bad        = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      IDLE: begin
        if (detect) begin
          if (stall) begin
            tgt_d   = sel_tgt;
            code_d  = flush_code;
            state_d = PENDING;
          end else begin
            fire        = 1'b1;
            fire_br     = (flush_code == BR_FLUSH) || (flush_code == NBR_FLUSH);
            redirect_pc = sel_tgt;
            shad_d      = SHADOW_LOAD;
            state_d     = SHADOW;
          end
        end
        set_bad = reset_n && id_valid && code_illegal;
      end
      PENDING: begin
        if (!stall) begin
          fire        = 1'b1;
          fire_br     = (code_q == BR_FLUSH) || (code_q == NBR_FLUSH);
          redirect_pc = tgt_q;
          shad_d      = SHADOW_LOAD;
          state_d     = SHADOW;
        end
      end
      SHADOW: begin
        if (!stall) begin
          if (shad_q <= SHADOW_LAST) begin
            shad_d  = '0;
            state_d = IDLE;
          end else begin
            shad_d = shad_q - SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating statistics and sticky illegal-code flag; clear has priority.
  always_comb begin
    mis_d = mis_q;
    br_d  = br_q;
    bad_d = bad_q;
    if (cnt_clear) begin
      mis_d = '0;
      br_d  = '0;
      bad_d = 1'b0;
    end else begin
      if (fire && (mis_q != '1)) mis_d = mis_q + CNT_WIDTH'(1);
      if (fire_br && (br_q != '1)) br_d = br_q + CNT_WIDTH'(1);
      if (set_bad) bad_d = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      code_q  <= '0;
      shad_q  <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      code_q  <= code_d;
      shad_q  <= shad_d;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mis_q <= '0;
      br_q  <= '0;
      bad_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
      br_q  <= br_d;
      bad_q <= bad_d;
    end
  end

  assign redirect_valid = fire;
  assign flush_if_id    = fire;
  assign busy           = (state_q != IDLE);
  assign mispred_cnt    = mis_q;
  assign br_mispred_cnt = br_q;
  assign bad_code       = bad_q;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboard bench for redirect_ctrl: two instances (default build and a
// CNT_WIDTH=2 / SHADOW_CYCLES=2 build) share stimulus; a spec-level model
// predicts each cycle's outputs and every redirect event.
module tb_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [2:0]  flush_code = 3'd0;
  logic        stall = 1'b0;
  logic        cnt_clear = 1'b0;
  logic [15:0] jmp_target = '0, br_target = '0, pc_1_ID = '0, jr_target = '0;

  logic        rv0, fl0, busy0, bad0;
  logic [15:0] pc0, mc0, bc0;
  logic        rv1, fl1, busy1, bad1;
  logic [15:0] pc1;
  logic [1:0]  mc1, bc1;

  always #5 clk = ~clk;

  redirect_ctrl #(.WORD_SIZE(16), .CNT_WIDTH(16), .SHADOW_CYCLES(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .flush_code(flush_code),
    .stall(stall), .jmp_target(jmp_target), .br_target(br_target),
    .pc_1_ID(pc_1_ID), .jr_target(jr_target), .cnt_clear(cnt_clear),
    .redirect_valid(rv0), .redirect_pc(pc0), .flush_if_id(fl0), .busy(busy0),
    .mispred_cnt(mc0), .br_mispred_cnt(bc0), .bad_code(bad0));

  redirect_ctrl #(.WORD_SIZE(16), .CNT_WIDTH(2), .SHADOW_CYCLES(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .flush_code(flush_code),
    .stall(stall), .jmp_target(jmp_target), .br_target(br_target),
    .pc_1_ID(pc_1_ID), .jr_target(jr_target), .cnt_clear(cnt_clear),
    .redirect_valid(rv1), .redirect_pc(pc1), .flush_if_id(fl1), .busy(busy1),
    .mispred_cnt(mc1), .br_mispred_cnt(bc1), .bad_code(bad1));

  typedef struct {
    bit          pend;
    logic [15:0] ptgt;
    bit          pbr;
    int          shadow_left;
    int          mcnt;
    int          bcnt;
    bit          bad;
  } mstate_t;

  typedef struct {
    logic        rv;
    logic        fl;
    logic        bsy;
    logic [15:0] pc;
    int          mc;
    int          bc;
    logic        bad;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] pc;
  } rev_t;

  mstate_t m[2];
  int      sh_cfg[2] = '{1, 2};
  int      cmax[2]   = '{65535, 3};

  exp_t sq0[$], sq1[$];
  rev_t rq0[$], rq1[$];

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  logic [15:0] nx_jmp = '0, nx_br = '0, nx_pc1 = '0, nx_jr = '0;
  logic        nx_rst = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc_n, act, exp);
    end
  endtask

  function automatic void model_clear(input int k);
    m[k].pend = 0; m[k].ptgt = '0; m[k].pbr = 0; m[k].shadow_left = 0;
    m[k].mcnt = 0; m[k].bcnt = 0; m[k].bad = 0;
  endfunction

  // Applies this cycle's inputs to model k; returns the outputs visible during
  // the cycle and whether a redirect happens, then advances to the next edge.
  function automatic exp_t model_step(input int k, output bit red, output logic [15:0] rpc);
    exp_t e;
    bit   setbad, isbr;
    logic [15:0] t;
    red = 0; rpc = '0; setbad = 0; isbr = 0;
    if (!reset_n) begin
      model_clear(k);
      e.rv = 0; e.fl = 0; e.bsy = 0; e.pc = '0; e.mc = 0; e.bc = 0; e.bad = 0;
      return e;
    end
    e.bsy = m[k].pend || (m[k].shadow_left > 0);
    e.mc  = m[k].mcnt;
    e.bc  = m[k].bcnt;
    e.bad = m[k].bad;
    if (m[k].pend) begin
      if (!stall) begin
        red = 1; rpc = m[k].ptgt; isbr = m[k].pbr;
        m[k].pend = 0; m[k].shadow_left = sh_cfg[k];
      end
    end else if (m[k].shadow_left > 0) begin
      if (!stall) m[k].shadow_left--;
    end else if (id_valid && flush_code >= 3'd1 && flush_code <= 3'd4) begin
      case (flush_code)
        3'd1:    t = jmp_target;
        3'd2:    t = br_target;
        3'd3:    t = pc_1_ID;
        default: t = jr_target;
      endcase
      if (stall) begin
        m[k].pend = 1; m[k].ptgt = t; m[k].pbr = (flush_code == 3'd2 || flush_code == 3'd3);
      end else begin
        red = 1; rpc = t; isbr = (flush_code == 3'd2 || flush_code == 3'd3);
        m[k].shadow_left = sh_cfg[k];
      end
    end else if (id_valid && flush_code >= 3'd5) begin
      setbad = 1;
    end
    e.rv = red; e.fl = red; e.pc = red ? rpc : 16'h0;
    if (cnt_clear) begin
      m[k].mcnt = 0; m[k].bcnt = 0; m[k].bad = 0;
    end else begin
      if (red && m[k].mcnt < cmax[k]) m[k].mcnt++;
      if (red && isbr && m[k].bcnt < cmax[k]) m[k].bcnt++;
      if (setbad) m[k].bad = 1;
    end
    return e;
  endfunction

  task automatic step(input bit v, input logic [2:0] c, input bit s, input bit clr);
    exp_t e;
    bit red;
    logic [15:0] rpc;
    rev_t r;
    @(posedge clk);
    #1;
    reset_n = nx_rst; id_valid = v; flush_code = c; stall = s; cnt_clear = clr;
    jmp_target = nx_jmp; br_target = nx_br; pc_1_ID = nx_pc1; jr_target = nx_jr;
    cyc_n++;
    e = model_step(0, red, rpc);
    sq0.push_back(e);
    if (red) begin r.cyc = cyc_n; r.pc = rpc; rq0.push_back(r); end
    e = model_step(1, red, rpc);
    sq1.push_back(e);
    if (red) begin r.cyc = cyc_n; r.pc = rpc; rq1.push_back(r); end
  endtask

  function automatic logic [63:0] pack_exp(input exp_t e);
    return {12'h0, e.rv, e.fl, e.bsy, e.pc, 16'(e.mc), 16'(e.bc), e.bad};
  endfunction

  exp_t me0, me1;
  rev_t mr;

  // Monitor: per-cycle status compare plus redirect-event matching.
  always @(negedge clk) begin
    if (sq0.size() > 0) begin
      me0 = sq0.pop_front();
      chk("status_d0", {12'h0, rv0, fl0, busy0, pc0, mc0, bc0, bad0}, pack_exp(me0));
    end
    if (sq1.size() > 0) begin
      me1 = sq1.pop_front();
      chk("status_d1", {12'h0, rv1, fl1, busy1, pc1, 14'h0, mc1, 14'h0, bc1, bad1}, pack_exp(me1));
    end
    if (rv0 === 1'b1) begin
      if (rq0.size() == 0) chk("spurious_redirect_d0", {32'h0, 16'h0, pc0}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        mr = rq0.pop_front();
        chk("redirect_d0", {16'h0, 32'(cyc_n), pc0}, {16'h0, 32'(mr.cyc), mr.pc});
      end
    end
    if (rv1 === 1'b1) begin
      if (rq1.size() == 0) chk("spurious_redirect_d1", {32'h0, 16'h0, pc1}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        mr = rq1.pop_front();
        chk("redirect_d1", {16'h0, 32'(cyc_n), pc1}, {16'h0, 32'(mr.cyc), mr.pc});
      end
    end
  end

  initial begin
    model_clear(0);
    model_clear(1);
    // Reset held, then released.
    nx_rst = 1'b0;
    step(0, 0, 0, 0);
    step(1, 3'd1, 0, 0);
    nx_rst = 1'b1;
    step(0, 0, 0, 0);

    // Jump redirect with immediate recovery.
    nx_jmp = 16'h0040;
    step(1, 3'd1, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    // Branch redirect deferred by a 3-cycle stall; targets go to garbage.
    nx_br = 16'h0100;
    step(1, 3'd2, 1, 0);
    nx_jmp = 16'hDEAD; nx_br = 16'hBEEF; nx_pc1 = 16'h1234; nx_jr = 16'h5678;
    step(1, 3'd4, 1, 0);
    step(1, 3'd1, 1, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    // Not-taken redirect, then a code in the shadow must be ignored.
    nx_pc1 = 16'h0021; nx_jr = 16'h0777;
    step(1, 3'd3, 0, 0);
    step(1, 3'd4, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    // Stall inside the first shadow cycle stretches the shadow.
    nx_jmp = 16'h0200;
    step(1, 3'd1, 0, 0);
    step(1, 3'd4, 1, 0);
    step(1, 3'd4, 0, 0);
    step(1, 3'd4, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    // Illegal code, with and without id_valid; then clear racing a redirect.
    step(1, 3'd6, 0, 0);
    step(0, 3'd6, 0, 0);
    step(0, 3'd7, 0, 0);
    step(1, 3'd1, 0, 1);
    repeat (3) step(0, 0, 0, 0);

    // Five redirects: the 2-bit build saturates at 3.
    for (int i = 0; i < 5; i++) begin
      nx_jr = 16'(16'h0300 + i);
      step(1, 3'd4, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
    end

    // Reset while PENDING; the latched redirect must never fire.
    nx_br = 16'h0ABC;
    step(1, 3'd2, 1, 0);
    step(0, 0, 1, 0);
    nx_rst = 1'b0;
    step(0, 0, 0, 0);
    nx_rst = 1'b1;
    repeat (4) step(0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      nx_jmp = 16'($urandom); nx_br = 16'($urandom);
      nx_pc1 = 16'($urandom); nx_jr = 16'($urandom);
      nx_rst = ($urandom_range(0, 199) != 0);
      step($urandom_range(0, 9) < 7,
           ($urandom_range(0, 9) < 7) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 49) == 0);
    end
    nx_rst = 1'b1;
    repeat (4) step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("drain_d0", 64'(sq0.size() + rq0.size()), 64'h0);
    chk("drain_d1", 64'(sq1.size() + rq1.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
